// File: rtl/arith_pkg.sv
// Shared arithmetic constants and the divider FSM state encoding.
package arith_pkg;
  localparam int          WIDTH    = 32;
  localparam int          DIV_ITER = 32;
  localparam logic [31:0] QUOT_SAT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit, subtract if it fits.
// No latency, no flow control; the remainder fed in is always below the divisor, so the top bit never carries.
module div_step
  import arith_pkg::*;
(
  input  logic [32:0] r_in,
  input  logic        bit_in,
  input  logic [31:0] divisor,
  output logic [32:0] r_out,
  output logic        q_bit
);

  logic [33:0] t;

  always_comb begin
    t     = {r_in, bit_in};
    q_bit = (t >= {2'b00, divisor});
    r_out = q_bit ? 33'(t - {2'b00, divisor}) : 33'(t);
  end

endmodule

// File: rtl/divider_32.sv
// 64/32 unsigned restoring divider: result 32 iterations after accept, exceptions resolved at accept.
// in_ready only in IDLE; the result is held in DONE until out_ready, so a stalled consumer blocks new work.
module divider_32
  import arith_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] r_q, r_d;
  logic [31:0] q_q, q_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;

  logic [32:0] step_r;
  logic        step_bit;

  div_step u_step (
    .r_in    (r_q),
    .bit_in  (q_q[31]),
    .divisor (dvsr_q),
    .r_out   (step_r),
    .q_bit   (step_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvsr_d = divisor;
          r_d    = {1'b0, dividend[63:32]};
          q_d    = dividend[31:0];
          cnt_d  = 5'd0;
          // Exceptions skip iteration entirely and publish the saturated result now.
          if (divisor == 32'd0) begin
            quot_d  = QUOT_SAT;
            rem_d   = dividend[31:0];
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else if (dividend[63:32] >= divisor) begin
            quot_d  = QUOT_SAT;
            rem_d   = dividend[31:0];
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        r_d   = step_r;
        q_d   = {q_q[30:0], step_bit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_ITER - 1)) begin
          quot_d  = {q_q[30:0], step_bit};
          rem_d   = step_r[31:0];
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      r_q     <= 33'd0;
      q_q     <= 32'd0;
      dvsr_q  <= 32'd0;
      quot_q  <= 32'd0;
      rem_q   <= 32'd0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_divider_32.sv
// Directed and random checks of divider_32 against an arithmetic reference, plus a div_step unit check.
module tb_divider_32;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  logic [32:0] ts_r;
  logic        ts_b;
  logic [31:0] ts_d;
  logic [32:0] ts_ro;
  logic        ts_qb;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  divider_32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  div_step u_step_tb (
    .r_in    (ts_r),
    .bit_in  (ts_b),
    .divisor (ts_d),
    .r_out   (ts_ro),
    .q_bit   (ts_qb)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; quotient not fitting 32 bits is overflow.
  task automatic run_op(input logic [63:0] a, input logic [31:0] b, input int hold);
    logic [63:0] qfull;
    logic [31:0] eq, er;
    logic        edz, eov;
    int          lat, elat;
    edz = 1'b0;
    eov = 1'b0;
    if (b == 32'd0) begin
      edz = 1'b1;
      eq  = 32'hFFFF_FFFF;
      er  = a[31:0];
    end else begin
      qfull = a / {32'd0, b};
      if (qfull > 64'h0000_0000_FFFF_FFFF) begin
        eov = 1'b1;
        eq  = 32'hFFFF_FFFF;
        er  = a[31:0];
      end else begin
        eq = qfull[31:0];
        er = 32'(a % {32'd0, b});
      end
    end
    elat = (edz || eov) ? 1 : 33;

    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 60);
    chk("latency", 64'(lat), 64'(elat));
    chk("quotient", {32'd0, quotient}, {32'd0, eq});
    chk("remainder", {32'd0, remainder}, {32'd0, er});
    chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, edz});
    chk("overflow", {63'd0, overflow}, {63'd0, eov});
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("released_out_valid", {63'd0, out_valid}, 64'd0);
    chk("released_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] sq, sr, rb, hi;
    logic        sdz, sov;
    logic [63:0] t;
    logic        eqb;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 64'd0;
    divisor   = 32'd0;
    ts_r      = 33'd0;
    ts_b      = 1'b0;
    ts_d      = 32'd1;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_quotient", {32'd0, quotient}, 64'd0);
    chk("rst_remainder", {32'd0, remainder}, 64'd0);
    chk("rst_flags", {62'd0, div_by_zero, overflow}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // div_step in isolation: new R = 2R+bit, minus divisor when it fits.
    for (int i = 0; i < 8; i++) begin
      ts_d = $urandom_range(1, 32'hFFFF_FFFF);
      if (i == 0) ts_d = 32'hFFFF_FFFF;
      ts_r = {1'b0, $urandom % ts_d};
      if (i == 0) ts_r = {1'b0, 32'hFFFF_FFFE};
      ts_b = 1'($urandom_range(0, 1));
      #1;
      t   = 64'(ts_r) * 2 + 64'(ts_b);
      eqb = (t >= 64'(ts_d));
      if (eqb) t = t - 64'(ts_d);
      chk("step_qbit", {63'd0, ts_qb}, {63'd0, eqb});
      chk("step_r", {31'd0, ts_ro}, t);
    end

    run_op(64'd100, 32'd7, 0);
    run_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1);
    run_op(64'h1234, 32'd0, 0);
    run_op(64'h0000_0002_0000_0000, 32'd2, 2);

    // Stall in DONE: outputs frozen, new operands ignored.
    @(negedge clk);
    dividend = 64'd1000;
    divisor  = 32'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    chk("stall_valid", {63'd0, out_valid}, 64'd1);
    sq  = quotient;
    sr  = remainder;
    sdz = div_by_zero;
    sov = overflow;
    chk("stall_q_value", {32'd0, sq}, 64'd333);
    dividend = 64'd77;
    divisor  = 32'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_outputs", {quotient, remainder}, {sq, sr});
      chk("stall_flags", {62'd0, div_by_zero, overflow}, {62'd0, sdz, sov});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("stall_release_out_valid", {63'd0, out_valid}, 64'd0);
    chk("stall_rem_value", {32'd0, sr}, 64'd1);

    // Reset during iteration 15 aborts the division.
    @(negedge clk);
    dividend = 64'h0000_0000_DEAD_BEEF;
    divisor  = 32'd13;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_outputs", {quotient, remainder}, 64'd0);
    chk("abort_flags", {62'd0, div_by_zero, overflow}, 64'd0);
    repeat (40) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("abort_no_result", {63'd0, out_valid}, 64'd0);
    rst_n = 1'b1;
    run_op(64'd9, 32'd4, 0);

    // Random operands, biased toward non-overflowing divisions.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) == 0) rb = 32'd0;
      else if ($urandom_range(0, 1) == 1) rb = $urandom;
      else rb = $urandom_range(1, 1000);
      if (rb != 32'd0 && $urandom_range(0, 4) != 0) hi = $urandom % rb;
      else hi = $urandom;
      run_op({hi, 32'($urandom)}, rb, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
